// File: rtl/data_memory_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: accepts one load or store,
// holds the pipeline for WAIT_CYCLES+1 cycles, then releases it for a single DONE cycle.
module data_memory_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_memory_read,
    input  logic        EX_MEM_memory_write,
    input  logic [31:0] EX_MEM_memory_address,
    input  logic [31:0] EX_MEM_write_data,
    output logic [31:0] DM_MEM_read_data,
    output logic        DM_stall,
    output logic        DM_error
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem [2**ADDR_W];

    logic any_req, misaligned, legal, illegal;
    logic accept, complete;

    // High address bits are deliberately dropped so out-of-range addresses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^EX_MEM_memory_address[31:ADDR_W+2];

    assign any_req    = EX_MEM_memory_read | EX_MEM_memory_write;
    assign misaligned = EX_MEM_memory_address[1:0] != 2'b00;
    assign legal      = (EX_MEM_memory_read ^ EX_MEM_memory_write) && !misaligned;
    assign illegal    = (EX_MEM_memory_read & EX_MEM_memory_write) | (any_req & misaligned);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        DM_stall = 1'b0;
        DM_error = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (legal) begin
                    accept   = 1'b1;
                    DM_stall = 1'b1;
                    cnt_d    = CntInit;
                    state_d  = StBusy;
                end else if (illegal) begin
                    DM_error = 1'b1;
                end
            end
            StBusy: begin
                DM_stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                // Inputs ignored here so the completing instruction cannot retrigger.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            DM_stall = 1'b0;
            DM_error = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_wr_q <= EX_MEM_memory_write;
                idx_q   <= EX_MEM_memory_address[ADDR_W+1:2];
                wdata_q <= EX_MEM_write_data;
            end
            if (complete && !op_wr_q) begin
                rdata_q <= mem[idx_q];
            end
        end
    end

    // Array has no reset; a store cut short by reset never reaches its completing edge.
    always_ff @(posedge clk) begin
        if (complete && op_wr_q && !rst) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign DM_MEM_read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: per-cycle vector table plus hand-written
// reset-abort and input-change-during-BUSY sequences.
module tb_data_memory_responder;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned WAIT_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    data_memory_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .EX_MEM_memory_read    (rd),
        .EX_MEM_memory_write   (wr),
        .EX_MEM_memory_address (addr),
        .EX_MEM_write_data     (wdata),
        .DM_MEM_read_data      (rdata),
        .DM_stall              (stall),
        .DM_error              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, sample at the falling edge.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic e_stall, input logic e_err, input logic [31:0] e_rdata,
                        input string name);
        @(posedge clk);
        #1;
        rd    = r;
        wr    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        chk({name, ".stall"}, {31'h0, stall}, {31'h0, e_stall});
        chk({name, ".error"}, {31'h0, err}, {31'h0, e_err});
        chk({name, ".rdata"}, rdata, e_rdata);
    endtask

    // Full access: accept cycle, WAIT_CYCLES busy cycles with alternate inputs, DONE cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] alt_a, input logic [31:0] alt_d,
                          input logic [31:0] prior, input logic [31:0] done_val,
                          input string name);
        step(r, w, a, d, 1'b1, 1'b0, prior, {name, ".accept"});
        for (int i = 0; i < int'(WAIT_CYCLES); i++) begin
            step(r, w, alt_a, alt_d, 1'b1, 1'b0, prior, {name, ".busy"});
        end
        step(r, w, alt_a, alt_d, 1'b0, 1'b0, done_val, {name, ".done"});
    endtask

    function automatic void add(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic s, input logic e,
                                input logic [31:0] q);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.stall = s; v.err = e; v.rdata = q;
        vecs.push_back(v);
    endfunction

    function automatic void add_access(input logic r, input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] prior,
                                       input logic [31:0] done_val);
        add(r, w, a, d, 1'b1, 1'b0, prior);
        for (int i = 0; i < int'(WAIT_CYCLES); i++) add(r, w, a, d, 1'b1, 1'b0, prior);
        add(r, w, a, d, 1'b0, 1'b0, done_val);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;

        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        add_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0);
        add_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
        add(1'b1, 1'b0, 32'h3, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        add(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        add(1'b0, 1'b1, 32'h12, 32'h55, 1'b0, 1'b1, 32'hDEADBEEF);
        add(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
        add_access(1'b0, 1'b1, 32'h0, 32'h1, 32'hDEADBEEF, 32'hDEADBEEF);
        add_access(1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 32'h1);
        // Word 4 must still hold DEADBEEF after the rejected misaligned store to 0x12.
        add_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h1, 32'hDEADBEEF);

        // Outputs forced low during reset, even with an illegal request present.
        repeat (2) @(posedge clk);
        #1;
        rd = 1'b1;
        wr = 1'b1;
        @(negedge clk);
        chk("reset.stall", {31'h0, stall}, 32'h0);
        chk("reset.error", {31'h0, err}, 32'h0);
        chk("reset.rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].stall, vecs[i].err, vecs[i].rdata, $sformatf("vec%0d", i));
        end

        // Reset during the second BUSY cycle of a store aborts it.
        access(1'b0, 1'b1, 32'h20, 32'h11223344, 32'h20, 32'h11223344,
               32'hDEADBEEF, 32'hDEADBEEF, "pre_store");
        step(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF, "abort.accept");
        step(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1, 1'b0, 32'hDEADBEEF, "abort.busy1");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort.rst_stall", {31'h0, stall}, 32'h0);
        chk("abort.rst_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        @(negedge clk);
        chk("abort.post_stall", {31'h0, stall}, 32'h0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 32'h20, 32'h0, 32'h0, 32'h11223344, "abort.load");

        // Input changes after acceptance must be ignored.
        access(1'b0, 1'b1, 32'h34, 32'h34343434, 32'h34, 32'h34343434,
               32'h11223344, 32'h11223344, "chg.pre");
        access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 32'h34, 32'h0BADF00D,
               32'h11223344, 32'h11223344, "chg.store");
        access(1'b1, 1'b0, 32'h34, 32'h0, 32'h34, 32'h0, 32'h11223344, 32'h34343434,
               "chg.load34");
        access(1'b1, 1'b0, 32'h30, 32'h0, 32'h34, 32'h0, 32'h34343434, 32'hCAFEF00D,
               "chg.load30");
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, "final.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
